// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the sequencer state encoding, the hard-wired zero register and default limits.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         MAX_MEM_WAIT_DEF = 15;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the ID and EX stages.
// Flags an ID source that matches the destination of a load currently in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  input  logic       memread_ex,
  input  logic [4:0] wreg_ex,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (wreg_ex == rs_id);
  assign rt_hit = uses_rt_id && (wreg_ex == rt_id);

  // Register zero never holds a produced value, so a load targeting it creates no hazard.
  assign lu = memread_ex && (wreg_ex != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and data-memory waits.
// Also watchdogs memory waits (sticky timeout) and counts stalled fetch cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_MEM_WAIT = MAX_MEM_WAIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             memread_ex,
  input  logic [4:0]       wreg_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_MEM_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       mem_block;

  load_use_detect u_lu (
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .uses_rt_id (uses_rt_id),
    .memread_ex (memread_ex),
    .wreg_ex    (wreg_ex),
    .lu         (lu)
  );

  assign mem_block = mem_req && !mem_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (mem_block) state_nxt = WAIT;
      WAIT: begin
        if (!mem_block)                  state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST)  state_nxt = ERR;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: every output gets a default before the priority chain, so no path can infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      // Reset keeps fetch frozen and feeds bubbles into ID/EX.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (state == ERR || mem_block) begin
      // Freeze everything; pending flush/bubble decisions replay once memory completes.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            wait_cnt <= '0;
    else if (state == ERR || !mem_block) wait_cnt <= '0;
    else                                wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state != ERR && !pc_write && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                timeout_err <= 1'b0;
    else if (state == WAIT && state_nxt == ERR) timeout_err <= 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic
// compared against a rule-level reference model (consecutive-block counter, sticky error, saturating stalls).
module tb_pipe_hazard_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  // Expected control vectors: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, pipe_hold}
  localparam logic [5:0] C_RST    = 6'b000110;
  localparam logic [5:0] C_HOLD   = 6'b000001;
  localparam logic [5:0] C_BRANCH = 6'b111110;
  localparam logic [5:0] C_LU     = 6'b000110;
  localparam logic [5:0] C_NORM   = 6'b110100;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs_id, rt_id, wreg_ex;
  logic          uses_rt_id, memread_ex, branch_taken_ex, mem_req, mem_ready;
  logic          pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, pipe_hold;
  logic          timeout_err;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  bit m_err;
  int m_blk;
  int m_stall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_MEM_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .uses_rt_id      (uses_rt_id),
    .memread_ex      (memread_ex),
    .wreg_ex         (wreg_ex),
    .branch_taken_ex (branch_taken_ex),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_bubble     (idex_bubble),
    .pipe_hold       (pipe_hold),
    .stall_cnt       (stall_cnt),
    .timeout_err     (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctrl_vec();
    return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, pipe_hold};
  endfunction

  // Reference decision from the stated priority rules.
  function automatic logic [5:0] model_ctrl();
    bit lu;
    lu = memread_ex && (wreg_ex != 5'd0) &&
         ((wreg_ex == rs_id) || (uses_rt_id && (wreg_ex == rt_id)));
    if (rst)                    return C_RST;
    if (m_err)                  return C_HOLD;
    if (mem_req && !mem_ready)  return C_HOLD;
    if (branch_taken_ex)        return C_BRANCH;
    if (lu)                     return C_LU;
    return C_NORM;
  endfunction

  task automatic idle();
    rs_id = 5'd1; rt_id = 5'd2; wreg_ex = 5'd3;
    uses_rt_id = 1'b0; memread_ex = 1'b0; branch_taken_ex = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Compare mid-cycle, then advance the model across the rising edge.
  task automatic cycle(input string tag);
    logic [5:0] e;
    @(negedge clk);
    e = model_ctrl();
    check({tag, ".ctrl"}, 32'(ctrl_vec()), 32'(e));
    check({tag, ".stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, ".terr"}, 32'(timeout_err), 32'(m_err));
    @(posedge clk);
    if (!m_err) begin
      if (mem_req && !mem_ready) begin
        m_blk++;
        if (m_blk == MAXW) m_err = 1'b1;
      end else begin
        m_blk = 0;
      end
      if (!e[5] && m_stall < SAT) m_stall++;
    end
    #1;
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_err = 1'b0; m_blk = 0; m_stall = 0;
    check("rst.ctrl", 32'(ctrl_vec()), 32'(C_RST));
    check("rst.stall", 32'(stall_cnt), 32'd0);
    check("rst.terr", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    do_reset();

    // Load-use on rs: one stalled fetch, then normal flow.
    memread_ex = 1'b1; wreg_ex = 5'd5; rs_id = 5'd5;
    cycle("lu");
    check("lu.cnt_after", 32'(stall_cnt), 32'd1);
    idle();
    cycle("lu_next");
    check("lu_next.pc_write", 32'(pc_write), 32'd1);

    // Register zero and an unused rt never stall.
    memread_ex = 1'b1; wreg_ex = 5'd0; rs_id = 5'd0;
    cycle("r0");
    wreg_ex = 5'd7; rt_id = 5'd7; rs_id = 5'd1; uses_rt_id = 1'b0;
    cycle("rt_unused");
    check("rt_unused.cnt", 32'(stall_cnt), 32'd1);
    uses_rt_id = 1'b1;
    cycle("rt_used");
    check("rt_used.cnt", 32'(stall_cnt), 32'd2);

    // Branch wins over a simultaneous load-use; no lost PC cycle.
    idle();
    branch_taken_ex = 1'b1; memread_ex = 1'b1; wreg_ex = 5'd5; rs_id = 5'd5;
    cycle("br_lu");
    check("br_lu.cnt", 32'(stall_cnt), 32'd2);

    // Memory wait with a frozen branch, released on ready.
    do_reset();
    idle();
    branch_taken_ex = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("mw_block");
    check("mw.cnt3", 32'(stall_cnt), 32'd3);
    mem_ready = 1'b1;
    cycle("mw_release");
    check("mw.cnt_final", 32'(stall_cnt), 32'd3);
    check("mw.terr", 32'(timeout_err), 32'd0);
    idle();
    cycle("mw_run");

    // Timeout after exactly MAXW blocked cycles; ERR holds until reset.
    do_reset();
    idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MAXW; i++) cycle("to_block");
    check("to.terr_set", 32'(timeout_err), 32'd1);
    idle();
    cycle("to_err_hold");
    check("to.hold", 32'(pipe_hold), 32'd1);
    do_reset();
    check("to.cleared", 32'(timeout_err), 32'd0);

    // Ready in the last permitted cycle completes without error.
    idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MAXW - 1; i++) cycle("edge_block");
    mem_ready = 1'b1;
    cycle("edge_ready");
    check("edge.terr", 32'(timeout_err), 32'd0);
    idle();
    cycle("edge_run");

    // Saturating stall counter.
    do_reset();
    idle();
    memread_ex = 1'b1; wreg_ex = 5'd9; rs_id = 5'd9;
    for (int i = 0; i < 20; i++) cycle("sat");
    check("sat.cnt", 32'(stall_cnt), 32'(SAT));

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      rs_id           = 5'($urandom_range(0, 3));
      rt_id           = 5'($urandom_range(0, 3));
      wreg_ex         = 5'($urandom_range(0, 3));
      uses_rt_id      = 1'($urandom_range(0, 1));
      memread_ex      = 1'($urandom_range(0, 1));
      branch_taken_ex = ($urandom_range(0, 3) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      mem_ready       = ($urandom_range(0, 2) == 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
